btn_debounce_pulse: RTL and testbench

//  Input conditioner between raw ui_in[3:0] push-buttons and the stopwatch control logic.
//  - Per channel: synchronise the raw button, debounce it and emit a clean level.
//  - Per channel: emit one-cycle press/release strobes that replace direct BTN0..BTN3 sampling.

---
 rtl/btn_pkg.sv | 16 +
 rtl/btn_debounce_ch.sv | 88 ++++++++
 rtl/btn_debounce_pulse.sv | 43 ++++
 tb/tb_btn_debounce_pulse.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared defaults and button index names for the push-button input conditioner.
// Defaults assume a 24 MHz core clock.
package btn_pkg;

    localparam int DEF_N_BTN           = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 240000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 12000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 2400000;   // 100 ms

    localparam int BTN_RESET = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_START = 3;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser chain, saturating debounce counter, level and 1-cycle strobes.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from a stable raw change; no backpressure.
// BTN_AUTOREPEAT_EN adds a held-button repeat counter that re-strobes press.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_stb,
    output logic release_stb
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   accept;
    logic                   repeat_hit;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            // Any return to the accepted level restarts the count (bounce rejection).
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt;

    // Suppressed on the release-accept cycle so press and release never coincide.
    assign repeat_hit = level && !accept && (rpt == RPT_FIRE);

    always_ff @(posedge clk) begin
        if (rst || !level || accept) begin
            rpt <= '0;
        end else if (repeat_hit) begin
            // Reloading lands the next fire exactly REPEAT_PERIOD cycles later.
            rpt <= RPT_RELOAD;
        end else begin
            rpt <= rpt + 1'b1;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
        end else begin
            press_stb   <= (accept && s) || repeat_hit;
            release_stb <= accept && !s;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: N_BTN independent debounced levels with press/release strobes.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges per accepted change; no backpressure.
// BTN_AUTOREPEAT_EN enables press auto-repeat while a button is held.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk         (CLK),
            .rst         (RST),
            .raw         (btn_raw[i]),
            .level       (btn_level[i]),
            .press_stb   (btn_press[i]),
            .release_stb (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed scenarios plus random button activity against a window model.
module tb_btn_debounce_pulse;

    localparam int NB   = 4;
    localparam int SS   = 2;
    localparam int DC   = 8;
    localparam int MAXE = 8000;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD   = 20;
    localparam int RP   = 5;
`endif

    logic          CLK;
    logic          RST;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    btn_debounce_pulse #(
        .N_BTN           (NB),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vec  = 0;
    int miss = 0;

    // Reference model: a change is accepted on edge k when the synchronised input
    // differed from the level on each of the DC edges ending at k, none of them a reset edge.
    int            ed = 0;
    int            lr = 0;
    logic [NB-1:0] hist [0:MAXE];
    logic [NB-1:0] m_level = '0;
    logic [NB-1:0] m_press = '0;
    logic [NB-1:0] m_rel   = '0;
    int            press_edge [NB];

    function automatic logic s_at(input int c, input int j);
        if (j - SS <= lr) return 1'b0;
        return hist[j-SS][c];
    endfunction

    always @(posedge CLK) begin
        bit ok;
        ed = ed + 1;
        if (ed <= MAXE) hist[ed] = btn_raw;
        if (RST) begin
            lr      = ed;
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                m_press[c] = 1'b0;
                m_rel[c]   = 1'b0;
                ok = (ed - DC + 1 > lr);
                for (int j = ed - DC + 1; j <= ed && ok; j++)
                    if (s_at(c, j) == m_level[c]) ok = 0;
                if (ok) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) begin
                        m_press[c]    = 1'b1;
                        press_edge[c] = ed;
                    end else begin
                        m_rel[c] = 1'b1;
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (m_level[c] && (ed - press_edge[c] >= RD) &&
                         ((ed - press_edge[c] - RD) % RP == 0)) begin
                    m_press[c] = 1'b1;
                end
`endif
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        chk("level",   32'(btn_level),   32'(m_level));
        chk("press",   32'(btn_press),   32'(m_press));
        chk("release", 32'(btn_release), 32'(m_rel));
        chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
    endtask

    int fp [NB];
    int np [NB];
    int fr [NB];
    int nr [NB];
    int pe3 [$];

    // Holds inputs for n cycles; records the first strobe edge (1-based) and strobe counts.
    task automatic run(input int n);
        for (int c = 0; c < NB; c++) begin
            fp[c] = -1; np[c] = 0; fr[c] = -1; nr[c] = 0;
        end
        pe3.delete();
        for (int k = 1; k <= n; k++) begin
            cyc();
            for (int c = 0; c < NB; c++) begin
                if (btn_press[c]) begin
                    np[c]++;
                    if (fp[c] < 0) fp[c] = k;
                end
                if (btn_release[c]) begin
                    nr[c]++;
                    if (fr[c] < 0) fr[c] = k;
                end
            end
            if (btn_press[3]) pe3.push_back(k);
        end
    endtask

    initial begin
        int acc;
        int hold [NB];
        logic [NB-1:0] rv;

        btn_raw = '0;
        RST     = 1'b1;
        cyc();
        cyc();
        chk("rst_level",   32'(btn_level),   32'd0);
        chk("rst_press",   32'(btn_press),   32'd0);
        chk("rst_release", 32'(btn_release), 32'd0);
        RST = 1'b0;
        run(4);

        // 1: single press, accepted on edge SS+DC
        btn_raw = 4'b0001;
        run(14);
        chk("t1_press_edge", 32'(fp[0]), 32'(SS + DC));
        chk("t1_press_cnt",  32'(np[0]), 32'd1);
        chk("t1_others",     32'(np[1] + np[2] + np[3] + nr[0]), 32'd0);
        chk("t1_level",      32'(btn_level), 32'b0001);

        // 2: bounce on channel 1 never accepted
        acc = 0;
        for (int r = 0; r < 5; r++) begin
            btn_raw[1] = 1'b1;
            run(3);
            acc += np[1] + nr[1];
            btn_raw[1] = 1'b0;
            run(3);
            acc += np[1] + nr[1];
        end
        chk("t2_strobes", 32'(acc), 32'd0);
        chk("t2_level",   32'(btn_level[1]), 32'd0);

        // 3: release after accepted press
        btn_raw[2] = 1'b1;
        run(14);
        chk("t3_press_edge", 32'(fp[2]), 32'(SS + DC));
        btn_raw[2] = 1'b0;
        run(14);
        chk("t3_release_edge", 32'(fr[2]), 32'(SS + DC));
        chk("t3_release_cnt",  32'(nr[2]), 32'd1);

        btn_raw = '0;
        run(14);

        // 4: reset on edge 6 of a count discards it
        btn_raw[3] = 1'b1;
        run(5);
        chk("t4_pre_rst", 32'(np[3]), 32'd0);
        RST = 1'b1;
        run(1);
        chk("t4_in_rst", 32'(np[3]), 32'd0);
        RST = 1'b0;
        run(14);
        chk("t4_press_edge", 32'(fp[3]), 32'(SS + DC));
        chk("t4_press_cnt",  32'(np[3]), 32'd1);

        btn_raw = '0;
        run(14);

        // 5: simultaneous presses on channels 0 and 3
        btn_raw = 4'b1001;
        run(14);
        chk("t5_press0_edge", 32'(fp[0]), 32'(SS + DC));
        chk("t5_press3_edge", 32'(fp[3]), 32'(SS + DC));
        chk("t5_level",       32'(btn_level), 32'b1001);

        btn_raw = '0;
        run(14);

`ifdef BTN_AUTOREPEAT_EN
        // 6: held button repeats at 10, 30, 35, ... 60
        btn_raw[3] = 1'b1;
        run(60);
        chk("t6_press_cnt", 32'(np[3]), 32'd8);
        for (int i = 0; i < pe3.size(); i++)
            chk("t6_press_edge", 32'(pe3[i]), (i == 0) ? 32'(SS + DC) : 32'(SS + DC + RD + RP * (i - 1)));
        btn_raw[3] = 1'b0;
        run(30);
        chk("t6_release_edge", 32'(fr[3]), 32'(SS + DC));
        acc = 0;
        for (int i = 0; i < pe3.size(); i++)
            if (pe3[i] >= fr[3]) acc++;
        chk("t6_press_after_release", 32'(acc), 32'd0);
`endif

        // Random activity: short bounces, holds across the threshold, long holds, rare resets
        rv = '0;
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    rv[c]   = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 60))
                                                          : int'($urandom_range(1, 14));
                end
                hold[c]--;
            end
            btn_raw = rv;
            RST     = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
